// File: rtl/fifo_pop_pkg.sv
// Shared types and default widths for the FIFO pop-side drain stage.
package fifo_pop_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int CNT_WIDTH_DEF  = 32;

endpackage

// File: rtl/fifo_pop_skid.sv
// Two-entry output buffer with its occupancy FSM; entry0 is the head of the stream.
module fifo_pop_skid
  import fifo_pop_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk_pop,
  input  logic                  rst,
  input  logic                  enq,
  input  logic [DATA_WIDTH-1:0] enq_data,
  input  logic                  deq,
  output logic [1:0]            occ,
  output logic [DATA_WIDTH-1:0] head
);

  occ_e                  occ_q, occ_d;
  logic [DATA_WIDTH-1:0] entry0_q, entry0_d;
  logic [DATA_WIDTH-1:0] entry1_q, entry1_d;

  always_comb begin
    // NOTE: defaults first so every path assigns each _d; a missing assignment would infer a latch.
    occ_d    = occ_q;
    entry0_d = entry0_q;
    entry1_d = entry1_q;
    case (occ_q)
      EMPTY: begin
        if (enq) begin
          occ_d    = ONE;
          entry0_d = enq_data;
        end
      end
      ONE: begin
        case ({enq, deq})
          2'b10: begin
            occ_d    = TWO;
            entry1_d = enq_data;
          end
          2'b01:   occ_d    = EMPTY;
          2'b11:   entry0_d = enq_data;
          default: ;
        endcase
      end
      TWO: begin
        // The pop decision never enqueues in TWO, so only a dequeue moves us.
        if (deq) begin
          occ_d    = ONE;
          entry0_d = entry1_q;
        end
      end
      default: occ_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk_pop) begin
    if (rst) begin
      // NOTE: both data entries are reset so m_data and entry1 read 0 after reset, not X.
      occ_q    <= EMPTY;
      entry0_q <= '0;
      entry1_q <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values of the others.
      occ_q    <= occ_d;
      entry0_q <= entry0_d;
      entry1_q <= entry1_d;
    end
  end

  assign occ  = occ_q;
  assign head = entry0_q;

endmodule

// File: rtl/fifo_pop_stream.sv
// Drains a first-word-fall-through FIFO pop port into a registered valid/ready stream,
// counting delivered beats and latching underflow errors.
module fifo_pop_stream
  import fifo_pop_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                  clk_pop,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  pop_empty,
  input  logic                  pop_error,
  input  logic [DATA_WIDTH-1:0] data_out,
  output logic                  pop_req_n,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  beat_cnt,
  output logic                  err_sticky,
  input  logic                  err_clr
);

  logic [1:0]           occ_raw;
  occ_e                 occ;
  logic                 pop;
  logic                 deq;
  logic [CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
  logic                 err_sticky_q, err_sticky_d;

  assign occ = occ_e'(occ_raw);

  // Pop depends only on registered occupancy, never on m_ready, so no ready-to-pop path.
  assign pop       = en & ~pop_empty & (occ != TWO) & ~rst;
  assign pop_req_n = ~pop;

  assign m_valid = (occ != EMPTY);
  assign deq     = m_valid & m_ready;

  fifo_pop_skid #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk_pop (clk_pop),
    .rst     (rst),
    .enq     (pop),
    .enq_data(data_out),
    .deq     (deq),
    .occ     (occ_raw),
    .head    (m_data)
  );

  always_comb begin
    beat_cnt_d   = beat_cnt_q + CNT_WIDTH'(deq);
    err_sticky_d = err_sticky_q;
    if (err_clr)   err_sticky_d = 1'b0;
    // Set has priority over clear when both arrive together.
    if (pop_error) err_sticky_d = 1'b1;
  end

  always_ff @(posedge clk_pop) begin
    if (rst) begin
      beat_cnt_q   <= '0;
      err_sticky_q <= 1'b0;
    end else begin
      beat_cnt_q   <= beat_cnt_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign beat_cnt   = beat_cnt_q;
  assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_fifo_pop_stream.sv
// Scoreboard bench: a queue-based FWFT FIFO model feeds the DUT, a monitor checks delivered words.
module tb_fifo_pop_stream;

  localparam int DW = 32;

  logic          clk_pop = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          pop_empty = 1'b1;
  logic          pop_error = 1'b0;
  logic [DW-1:0] data_out = '0;
  logic          pop_req_n;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready = 1'b0;
  logic [31:0]   beat_cnt;
  logic          err_sticky;
  logic          err_clr = 1'b0;

  logic          pop_req_n4, m_valid4, err_sticky4;
  logic [DW-1:0] m_data4;
  logic [3:0]    beat_cnt4;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  logic          gap = 1'b0;
  logic          popped;
  int            n_vec = 0;
  int            n_err = 0;
  int            n_pops = 0;
  int            n_beats = 0;

  always #5 clk_pop = ~clk_pop;

  fifo_pop_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(32)) u_dut (
    .clk_pop(clk_pop), .rst(rst), .en(en), .pop_empty(pop_empty), .pop_error(pop_error),
    .data_out(data_out), .pop_req_n(pop_req_n), .m_valid(m_valid), .m_data(m_data),
    .m_ready(m_ready), .beat_cnt(beat_cnt), .err_sticky(err_sticky), .err_clr(err_clr)
  );

  fifo_pop_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(4)) u_dut4 (
    .clk_pop(clk_pop), .rst(rst), .en(en), .pop_empty(pop_empty), .pop_error(pop_error),
    .data_out(data_out), .pop_req_n(pop_req_n4), .m_valid(m_valid4), .m_data(m_data4),
    .m_ready(m_ready), .beat_cnt(beat_cnt4), .err_sticky(err_sticky4), .err_clr(err_clr)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic load(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
  endtask

  // One clock cycle, entered and left on a falling edge; inputs are set before calling.
  task automatic tick();
    pop_empty = (fifo_q.size() == 0) || gap;
    data_out  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    #1;
    popped = ~pop_req_n;
    if (popped) n_pops++;
    @(posedge clk_pop);
    if (popped && fifo_q.size() != 0) void'(fifo_q.pop_front());
    @(negedge clk_pop);
  endtask

  task automatic drain(input string name);
    int budget;
    budget = 40;
    while ((m_valid || fifo_q.size() != 0) && budget > 0) begin
      tick();
      budget--;
    end
    check(name, {63'd0, m_valid || fifo_q.size() != 0}, 64'd0);
  endtask

  // Monitor: mid-cycle, a valid & ready pair means a beat at the coming edge.
  initial begin
    forever begin
      @(negedge clk_pop);
      #2;
      if (!rst && m_valid && m_ready) begin
        n_beats++;
        if (exp_q.size() == 0) begin
          check("unexpected_beat", {32'd0, m_data}, 64'hDEAD);
        end else begin
          check("stream_word", {32'd0, m_data}, {32'd0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    int pops0;
    int beats0;
    @(negedge clk_pop);

    // Reset: pop_req_n high during rst, then fill to TWO, set the error and reset again.
    tick();
    check("rst_no_pop", {63'd0, popped}, 64'd0);
    check("rst_m_valid", {63'd0, m_valid}, 64'd0);
    check("rst_m_data", {32'd0, m_data}, 64'd0);
    rst = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 4; i++) load(32'hA0 + i);
    pop_error = 1'b1;
    tick();
    pop_error = 1'b0;
    tick();
    tick();
    check("fill_two_m_data", {32'd0, m_data}, 64'hA0);
    check("fill_two_stop", {63'd0, popped}, 64'd0);
    check("err_set", {63'd0, err_sticky}, 64'd1);
    rst = 1'b1;
    tick();
    check("rst_cycle_no_pop", {63'd0, popped}, 64'd0);
    check("rst_clears_valid", {63'd0, m_valid}, 64'd0);
    check("rst_clears_cnt", {32'd0, beat_cnt}, 64'd0);
    check("rst_clears_err", {63'd0, err_sticky}, 64'd0);
    tick();
    check("rst_hold_no_pop", {63'd0, popped}, 64'd0);
    fifo_q.delete();
    exp_q.delete();
    rst = 1'b0;

    // Streaming: 16 words, one per cycle, first visible the cycle after its pop.
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) load(i);
    for (int i = 0; i < 16; i++) begin
      tick();
      check("stream_pop", {63'd0, popped}, 64'd1);
      check("stream_valid", {63'd0, m_valid}, 64'd1);
    end
    tick();
    check("stream_done_valid", {63'd0, m_valid}, 64'd0);
    check("stream_cnt", {32'd0, beat_cnt}, 64'd16);
    check("stream_cnt4", {60'd0, beat_cnt4}, 64'd0);
    load(32'h55);
    tick();
    tick();
    check("wrap_cnt4", {60'd0, beat_cnt4}, 64'd1);
    check("wrap_cnt", {32'd0, beat_cnt}, 64'd17);

    // Backpressure: only two pops while stalled, head held, one-cycle pop gap on release.
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) load(32'h10 + i);
    pops0 = n_pops;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_data", {32'd0, m_data}, 64'h10);
    end
    check("bp_pops", n_pops - pops0, 64'd2);
    m_ready = 1'b1;
    tick();
    check("bp_resume_gap", {63'd0, popped}, 64'd0);
    tick();
    check("bp_resume_pop", {63'd0, popped}, 64'd1);
    drain("bp_drain");

    // Empty gaps: pop_empty forced high every other cycle.
    for (int i = 0; i < 6; i++) load(32'h20 + i);
    for (int i = 0; i < 12; i++) begin
      gap = i[0];
      tick();
      if (gap) check("gap_no_pop", {63'd0, popped}, 64'd0);
    end
    gap = 1'b0;
    drain("gap_drain");

    // Enable: drop en with TWO buffered; exactly the two buffered words come out.
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) load(32'h30 + i);
    tick();
    tick();
    tick();
    en = 1'b0;
    m_ready = 1'b1;
    beats0 = n_beats;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("en_off_no_pop", {63'd0, popped}, 64'd0);
    end
    check("en_off_beats", n_beats - beats0, 64'd2);
    check("en_off_valid", {63'd0, m_valid}, 64'd0);
    check("en_off_req_n", {63'd0, pop_req_n}, 64'd1);
    en = 1'b1;
    drain("en_drain");

    // Errors: set wins over a simultaneous clear; a lone clear drops it.
    pop_error = 1'b1;
    err_clr = 1'b1;
    tick();
    pop_error = 1'b0;
    err_clr = 1'b0;
    check("err_set_wins", {63'd0, err_sticky}, 64'd1);
    tick();
    check("err_holds", {63'd0, err_sticky}, 64'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("err_cleared", {63'd0, err_sticky}, 64'd0);

    check("scoreboard_empty", exp_q.size(), 64'd0);
    check("final_cnt", {32'd0, beat_cnt}, 64'd32);
    check("final_cnt4", {60'd0, beat_cnt4}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
